// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_count output.
module riscv_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] ir_data,
   output logic [31:0] ir_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW+1:0] DEPTH_S = (CW + 2)'(FIFO_DEPTH);

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
   logic [CW+1:0] credit_used;
   logic [31:0]   target_pc;
   logic          req_fire, push, drop, pop;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign target_pc = {redirect_pc[31:2], 2'b00};

   // Stale in-flight words still hold a credit until they come back.
   assign credit_used = {2'b00, count_q} + {2'b00, outst_q} + {2'b00, discard_q};

   assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_S);
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign ir_valid = !rst && (count_q != '0);
   assign ir_data  = ir_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign ir_pc    = ir_valid ? fifo_pc_q[rd_ptr_q] : '0;

   assign pop  = ir_valid && ir_ready && !redirect_valid;
   assign push = imem_rsp_valid && (state_q == StRun) && !redirect_valid;
   assign drop = imem_rsp_valid && (state_q == StDrain) && !redirect_valid;

   always_comb begin
      pc_d      = pc_q;
      rsp_pc_d  = rsp_pc_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      outst_d   = outst_q;
      discard_d = discard_q;
      state_d   = state_q;
      if (redirect_valid) begin
         pc_d      = target_pc;
         rsp_pc_d  = target_pc;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         outst_d   = '0;
         // A response landing this cycle is one of the old ones and is dropped.
         discard_d = discard_q + outst_q - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d   = count_q + CW'(push) - CW'(pop);
         outst_d   = outst_q + CW'(req_fire) - CW'(push);
         discard_d = discard_q - CW'(drop);
      end
      unique case (state_q)
         StRun:   if (discard_d != '0) state_d = StDrain;
         StDrain: if (discard_d == '0) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         pc_q      <= RESET_PC;
         rsp_pc_q  <= RESET_PC;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         outst_q   <= '0;
         discard_q <= '0;
      end else begin
         assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
         state_q   <= state_d;
         pc_q      <= pc_d;
         rsp_pc_q  <= rsp_pc_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= imem_rsp_data;
         fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (ir_ready && !ir_valid && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order memory model plus a transaction-level stream
// scoreboard; honours FETCH_STALL_CNT_EN.
module tb_riscv_fetch_unit;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        ir_valid, ir_ready = 1'b1;
   logic [31:0] ir_data, ir_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   riscv_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .ir_data        (ir_data),
      .ir_pc          (ir_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_count    (stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
      logic [31:0] ep;
   } req_t;

   int          n_vec = 0;
   int          n_err = 0;
   req_t        mq[$];
   int unsigned cyc = 0;
   int unsigned last_due = 0;
   int unsigned epoch = 0;
   int unsigned rsp_epoch = 0;
   int          held = 0;
   logic [31:0] exp_req_pc = RPC;
   logic [31:0] exp_ir_pc = RPC;
   logic [31:0] stall_exp = '0;
   int unsigned lat_min = 1, lat_max = 1;
   bit          rand_ready = 0, rand_ir = 0;
   int unsigned ready_pct = 100;
   int          fires = 0, pops = 0;
   logic [31:0] first_pop_pc, first_pop_data, last_pop_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'h5A5A_C3C3;
   endfunction

   // One clock: scoreboard at the falling edge, then memory model and drive after the rise.
   task automatic tick();
      bit          was_rst, fire_req, do_pop;
      logic [31:0] f_addr;
      int unsigned f_ep, lat, due, inflight;
      bit          exp_rv;
      @(negedge clk);
      was_rst  = rst;
      fire_req = 0;
      f_addr   = '0;
      f_ep     = epoch;
      if (!was_rst) begin
         inflight = mq.size() + (imem_rsp_valid ? 1 : 0);
         exp_rv   = !redirect_valid && (inflight + held < DEPTH);
         n_vec++;
         if (ir_valid !== (held > 0)) begin
            n_err++;
            $display("FAIL ir_valid cyc=%0d got=%b want=%b", cyc, ir_valid, held > 0);
         end
         n_vec++;
         if (imem_req_valid !== exp_rv) begin
            n_err++;
            $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, exp_rv);
         end
         if (imem_req_valid === 1'b1) begin
            n_vec++;
            if (imem_addr !== exp_req_pc) begin
               n_err++;
               $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_addr, exp_req_pc);
            end
         end
         if (ir_valid === 1'b1 && held > 0) begin
            n_vec++;
            if (ir_pc !== exp_ir_pc || ir_data !== mem_word(exp_ir_pc)) begin
               n_err++;
               $display("FAIL ir_head cyc=%0d got pc=%h data=%h want pc=%h data=%h", cyc, ir_pc,
                        ir_data, exp_ir_pc, mem_word(exp_ir_pc));
            end
         end
`ifdef FETCH_STALL_CNT_EN
         n_vec++;
         if (stall_count !== stall_exp) begin
            n_err++;
            $display("FAIL stall_count cyc=%0d got=%0d want=%0d", cyc, stall_count, stall_exp);
         end
         if (ir_ready && !ir_valid && stall_exp != '1) stall_exp = stall_exp + 1;
`endif
         fire_req = imem_req_valid && imem_req_ready;
         if (fire_req) begin
            f_addr     = imem_addr;
            exp_req_pc = exp_req_pc + 32'd4;
            fires++;
         end
         do_pop = ir_valid && ir_ready && !redirect_valid;
         if (do_pop) begin
            pops++;
            if (pops == 1) begin
               first_pop_pc   = ir_pc;
               first_pop_data = ir_data;
            end
            last_pop_pc = ir_pc;
            if (held > 0) held--;
            exp_ir_pc = exp_ir_pc + 32'd4;
         end
         if (imem_rsp_valid && !redirect_valid && rsp_epoch == epoch) held++;
         if (redirect_valid) begin
            held       = 0;
            epoch++;
            exp_req_pc = {redirect_pc[31:2], 2'b00};
            exp_ir_pc  = {redirect_pc[31:2], 2'b00};
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) begin
         mq.delete();
         held       = 0;
         epoch++;
         exp_req_pc = RPC;
         exp_ir_pc  = RPC;
         stall_exp  = '0;
      end else if (fire_req) begin
         lat = $urandom_range(lat_max, lat_min);
         due = cyc - 1 + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{addr: f_addr, due: due, ep: f_ep});
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
         rsp_epoch      = mq[0].ep;
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom();
      end
      if (rand_ready) imem_req_ready = ($urandom_range(99) < ready_pct);
      if (rand_ir) ir_ready = 1'($urandom_range(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         n_vec++;
         if (imem_req_valid !== 1'b0 || ir_valid !== 1'b0 || ir_data !== '0 || ir_pc !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got req=%b irv=%b data=%h pc=%h want 0 0 0 0",
                     imem_req_valid, ir_valid, ir_data, ir_pc);
         end
      end
   endtask

   task automatic test_startup();
      rst = 1'b0;
      lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; ir_ready = 1'b1;
      #1;
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_addr !== RPC) begin
         n_err++;
         $display("FAIL first_req got v=%b a=%h want 1 %h", imem_req_valid, imem_addr, RPC);
      end
      pops = 0;
      tick(); #1;
      n_vec++;
      if (ir_valid !== 1'b0) begin
         n_err++;
         $display("FAIL latency_c1 got=%b want=0", ir_valid);
      end
      tick(); #1;
      n_vec++;
      if (ir_valid !== 1'b1 || ir_pc !== RPC) begin
         n_err++;
         $display("FAIL latency_c2 got v=%b pc=%h want 1 %h", ir_valid, ir_pc, RPC);
      end
      repeat (16) tick();
      n_vec++;
      if (pops != 16) begin
         n_err++;
         $display("FAIL throughput got=%0d want=16", pops);
      end
   endtask

   task automatic test_backpressure();
      lat_min = 1; lat_max = 1; ir_ready = 1'b0;
      do_reset();
      fires = 0;
      repeat (10) tick();
      #1;
      n_vec++;
      if (fires != DEPTH || imem_req_valid !== 1'b0 || ir_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_fill got fires=%0d req=%b irv=%b want %0d 0 1", fires,
                  imem_req_valid, ir_valid, DEPTH);
      end
      ir_ready = 1'b1;
      pops = 0;
      tick(); #1;
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
         n_err++;
         $display("FAIL bp_resume got v=%b a=%h want 1 00000010", imem_req_valid, imem_addr);
      end
      repeat (3) tick();
      n_vec++;
      if (pops != 4 || last_pop_pc !== 32'hC) begin
         n_err++;
         $display("FAIL bp_drain got pops=%0d last=%h want 4 0000000c", pops, last_pop_pc);
      end
   endtask

   task automatic test_redirect_inflight();
      lat_min = 4; lat_max = 4; ir_ready = 1'b1;
      do_reset();
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      pops = 0;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_vec++;
      if (ir_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL redir_next got irv=%b req=%b a=%h want 0 1 00000100", ir_valid,
                  imem_req_valid, imem_addr);
      end
      for (int i = 0; i < 30 && pops == 0; i++) tick();
      n_vec++;
      if (pops == 0 || first_pop_pc !== 32'h100 || first_pop_data !== mem_word(32'h100)) begin
         n_err++;
         $display("FAIL redir_first got pops=%0d pc=%h data=%h want pc=00000100 data=%h", pops,
                  first_pop_pc, first_pop_data, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_collide();
      lat_min = 1; lat_max = 1; ir_ready = 1'b1;
      do_reset();
      repeat (6) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      #1;
      n_vec++;
      if (ir_valid !== 1'b1) begin
         n_err++;
         $display("FAIL collide_pre got irv=%b want 1", ir_valid);
      end
      pops = 0;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_vec++;
      if (ir_valid !== 1'b0) begin
         n_err++;
         $display("FAIL collide_flush got irv=%b want 0", ir_valid);
      end
      for (int i = 0; i < 20 && pops == 0; i++) tick();
      n_vec++;
      if (pops == 0 || first_pop_pc !== 32'h200) begin
         n_err++;
         $display("FAIL collide_first got pops=%0d pc=%h want 00000200", pops, first_pop_pc);
      end
   endtask

   task automatic test_wrap_align();
      lat_min = 1; lat_max = 1; ir_ready = 1'b1;
      do_reset();
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL wrap_a0 got v=%b a=%h want 1 fffffffc", imem_req_valid, imem_addr);
      end
      pops = 0;
      tick(); #1;
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_a1 got v=%b a=%h want 1 00000000", imem_req_valid, imem_addr);
      end
      for (int i = 0; i < 20 && pops < 2; i++) tick();
      n_vec++;
      if (pops != 2 || first_pop_pc !== 32'hFFFF_FFFC || last_pop_pc !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_pops got n=%0d first=%h last=%h want 2 fffffffc 00000000", pops,
                  first_pop_pc, last_pop_pc);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL align got v=%b a=%h want 1 00000100", imem_req_valid, imem_addr);
      end
   endtask

   task automatic test_reset_midstream();
      lat_min = 1; lat_max = 1; ir_ready = 1'b0;
      repeat (8) tick();
      #1;
      n_vec++;
      if (ir_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_full got irv=%b req=%b want 1 0", ir_valid, imem_req_valid);
      end
      do_reset();
      n_vec++;
      if (ir_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RPC) begin
         n_err++;
         $display("FAIL mid_reset got irv=%b req=%b a=%h want 0 1 %h", ir_valid, imem_req_valid,
                  imem_addr, RPC);
      end
`ifdef FETCH_STALL_CNT_EN
      n_vec++;
      if (stall_count !== 32'd0) begin
         n_err++;
         $display("FAIL stall_reset got=%0d want=0", stall_count);
      end
`endif
      ir_ready = 1'b1;
      repeat (2) tick();
      #1;
`ifdef FETCH_STALL_CNT_EN
      n_vec++;
      if (stall_count !== 32'd2) begin
         n_err++;
         $display("FAIL stall_after got=%0d want=2", stall_count);
      end
`endif
      n_vec++;
      if (ir_valid !== 1'b1 || ir_pc !== RPC) begin
         n_err++;
         $display("FAIL mid_restart got irv=%b pc=%h want 1 %h", ir_valid, ir_pc, RPC);
      end
   endtask

   task automatic test_random();
      bit prev_redir;
      lat_min = 1; lat_max = 4;
      do_reset();
      rand_ready = 1; ready_pct = 70; rand_ir = 1;
      prev_redir = 0;
      for (int i = 0; i < 3000; i++) begin
         redirect_valid = ($urandom_range(39) == 0) || (prev_redir && $urandom_range(1) == 1);
         if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         else redirect_pc = $urandom();
         prev_redir = redirect_valid;
         tick();
      end
      redirect_valid = 1'b0;
      rand_ready = 0; rand_ir = 0;
      imem_req_ready = 1'b1; ir_ready = 1'b1;
      repeat (20) tick();
   endtask

   initial begin
      test_reset();
      test_startup();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_collide();
      test_wrap_align();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
